div_issue_ctrl: RTL

- Initiator side of the multi-cycle divider handshake, sitting in the EXU between DIV/DIVU issue and the unsigned 32-cycle restoring divider.
- Accepts one divide request at a time, converts signed operands to magnitudes and drives the divider's valid/a/b.
- Waits for done, applies sign correction, then returns a one-cycle HI/LO response.
- Handles divide-by-zero without using the divider, and handles pipeline flush while a divide is in flight.

---
 rtl/div_issue_ctrl_if.sv | 31 +++
 rtl/div_issue_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl_if.sv
// Signal bundle between the divide issue controller, the EXU issue stage and the divider.
interface div_issue_ctrl_if;
    localparam int unsigned XLEN = 32;

    logic              req_valid;
    logic              req_ready;
    logic              req_signed;
    logic [XLEN-1:0]   req_a;
    logic [XLEN-1:0]   req_b;
    logic              flush;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_hi;
    logic [XLEN-1:0]   resp_lo;
    logic              div_valid;
    logic [XLEN-1:0]   div_a;
    logic [XLEN-1:0]   div_b;
    logic              div_done;
    logic [2*XLEN-1:0] div_res;

    // Controller view.
    modport slave (
        input  req_valid, req_signed, req_a, req_b, flush, div_done, div_res,
        output req_ready, resp_valid, resp_hi, resp_lo, div_valid, div_a, div_b
    );

    // Issue stage plus divider view.
    modport master (
        output req_valid, req_signed, req_a, req_b, flush, div_done, div_res,
        input  req_ready, resp_valid, resp_hi, resp_lo, div_valid, div_a, div_b
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// DIV/DIVU issue controller: converts signed operands to magnitudes, drives the
// unsigned divider, applies sign correction and handles divide-by-zero and flush.
module div_issue_ctrl #(
    parameter logic [31:0] ZERO_DIV_LO = 32'hFFFF_FFFF
) (
    input logic             clk,
    input logic             reset,
    div_issue_ctrl_if.slave bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIX,
        S_DRAIN,
        S_ZERO
    } state_t;

    state_t          state_q, state_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic            drain_done_q, drain_done_d;
    logic [XLEN-1:0] orig_a_q, orig_a_d;
    logic            div_valid_q, div_valid_d;
    logic [XLEN-1:0] div_a_q, div_a_d;
    logic [XLEN-1:0] div_b_q, div_b_d;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_hi_q, resp_hi_d;
    logic [XLEN-1:0] resp_lo_q, resp_lo_d;

    logic            accept;
    logic            req_sa;
    logic            req_sb;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;

    assign accept = bus.req_valid && !bus.flush;
    assign req_sa = bus.req_signed & bus.req_a[XLEN-1];
    assign req_sb = bus.req_signed & bus.req_b[XLEN-1];
    assign quo    = bus.div_res[XLEN-1:0];
    assign rem    = bus.div_res[2*XLEN-1:XLEN];

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        drain_done_d = 1'b0;
        orig_a_d     = orig_a_q;
        div_valid_d  = 1'b0;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        resp_valid_d = 1'b0;
        resp_hi_d    = resp_hi_q;
        resp_lo_d    = resp_lo_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sa_d     = req_sa;
                    sb_d     = req_sb;
                    orig_a_d = bus.req_a;
                    div_a_d  = req_sa ? XLEN'(-bus.req_a) : bus.req_a;
                    div_b_d  = req_sb ? XLEN'(-bus.req_b) : bus.req_b;
                    if (bus.req_b == '0) begin
                        state_d = S_ZERO;
                    end else begin
                        state_d     = S_ISSUE;
                        div_valid_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = bus.flush ? S_DRAIN : S_WAIT;
            end
            // done is high while the divider idles, so it only counts from here on.
            S_WAIT: begin
                if (bus.div_done) begin
                    state_d      = bus.flush ? S_DRAIN : S_FIX;
                    drain_done_d = bus.flush;
                end else if (bus.flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    resp_valid_d = 1'b1;
                    resp_hi_d    = sa_q ? XLEN'(-rem) : rem;
                    resp_lo_d    = (sa_q ^ sb_q) ? XLEN'(-quo) : quo;
                end
            end
            // Divider cannot abort: wait for done, then one cycle for it to reach INIT.
            S_DRAIN: begin
                if (drain_done_q) begin
                    state_d = S_IDLE;
                end else begin
                    drain_done_d = bus.div_done;
                end
            end
            S_ZERO: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    resp_valid_d = 1'b1;
                    resp_hi_d    = orig_a_q;
                    resp_lo_d    = ZERO_DIV_LO;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sa_q         <= 1'b0;
            sb_q         <= 1'b0;
            drain_done_q <= 1'b0;
            orig_a_q     <= '0;
            div_valid_q  <= 1'b0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_hi_q    <= '0;
            resp_lo_q    <= '0;
        end else begin
            state_q      <= state_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            drain_done_q <= drain_done_d;
            orig_a_q     <= orig_a_d;
            div_valid_q  <= div_valid_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            resp_valid_q <= resp_valid_d;
            resp_hi_q    <= resp_hi_d;
            resp_lo_q    <= resp_lo_d;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.div_valid  = div_valid_q;
    assign bus.div_a      = div_a_q;
    assign bus.div_b      = div_b_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_hi    = resp_hi_q;
    assign bus.resp_lo    = resp_lo_q;
endmodule
